// File: rtl/echip_serial_pkg.sv
// Shared types and helpers for the echip65 decimated-data serial link receiver.
package echip_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  localparam int DATA_WIDTH_DEF = 25;
  localparam int CH_BITS_DEF    = 2;

  // Widest channel+data payload that frame_parity can cover.
  localparam int PAYLOAD_MAX = 64;

  // Total bits on the line per frame: channel ID, data word, parity bit.
  function automatic int frame_len(input int ch_bits, input int data_width);
    return ch_bits + data_width + 1;
  endfunction

  // Even-parity bit over a zero-extended {ch, data} payload.
  function automatic logic frame_parity(input logic [PAYLOAD_MAX-1:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/echip_serial_rx.sv
// Off-chip receiver for the echip65 serial link: deserializes framed
// {ch, data, parity} words, checks even parity, and presents good words on a
// valid/ready port while counting link errors.
module echip_serial_rx
  import echip_serial_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int CH_BITS       = CH_BITS_DEF,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sdata,
  input  logic                     sframe,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [CH_BITS-1:0]       out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overrun,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  input  logic                     clear_err
);

  localparam int FRAME_LEN = frame_len(CH_BITS, DATA_WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int PAY_W     = CH_BITS + DATA_WIDTH;

  // bitcnt holds the number of bits already shifted in; the parity bit is
  // the one arriving while bitcnt == FRAME_LEN-1.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  rx_state_e                state_q, state_d;
  logic [CNT_W-1:0]         bitcnt_q, bitcnt_d;
  logic [FRAME_LEN-1:0]     shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [CH_BITS-1:0]       out_ch_q, out_ch_d;
  logic                     out_valid_q, out_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     parity_err_q, parity_err_d;
  logic                     overrun_q, overrun_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic [FRAME_LEN-1:0]     shifted;
  logic                     frame_done;
  logic                     parity_ok;
  logic                     overrun_set;
  logic                     err_event;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign shifted   = {shreg_q[FRAME_LEN-2:0], sdata};
  assign parity_ok = (frame_parity(PAYLOAD_MAX'(shifted[FRAME_LEN-1:1])) == shifted[0]);

  // Receive FSM: frame alignment, bit counting and shift register.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    frame_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && sframe) begin
          shreg_d  = shifted;
          bitcnt_d = CNT_ONE;
          state_d  = RECV;
        end
      end
      RECV: begin
        if (!enable) begin
          // Abort quietly; the partial frame is overwritten by the next one.
          state_d  = IDLE;
          bitcnt_d = '0;
        end else if (sframe) begin
          // Resynchronise on the new strobe: this bit starts a fresh frame.
          frame_err_d = 1'b1;
          shreg_d     = shifted;
          bitcnt_d    = CNT_ONE;
        end else begin
          shreg_d = shifted;
          if (bitcnt_q == LAST_IDX) begin
            frame_done = 1'b1;
            state_d    = IDLE;
            bitcnt_d   = '0;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        bitcnt_d = '0;
      end
    endcase
  end

  // Frame evaluation, output slot handshake and error accounting.
  always_comb begin
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = out_valid_q && !out_ready;
    parity_err_d = 1'b0;
    overrun_set  = 1'b0;
    if (frame_done) begin
      if (!parity_ok) begin
        parity_err_d = 1'b1;
      end else if (!out_valid_q || out_ready) begin
        out_ch_d    = shifted[FRAME_LEN-1 -: CH_BITS];
        out_data_d  = shifted[DATA_WIDTH:1];
        out_valid_d = 1'b1;
      end else begin
        // Keep the unconsumed word; the new one is lost.
        overrun_set = 1'b1;
      end
    end
    err_event = frame_err_d || parity_err_d || overrun_set;
    if (clear_err) begin
      overrun_d   = 1'b0;
      err_count_d = '0;
    end else begin
      overrun_d   = overrun_q || overrun_set;
      err_count_d = err_event ? sat_inc(err_count_q) : err_count_q;
    end
  end

  // State and output registers; everything clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign err_count  = err_count_q;

endmodule
